// File: rtl/popcount_pkg.sv
// Shared types and width helpers for the popcount family.
package popcount_pkg;

  localparam int unsigned DEF_CHUNK_W   = 19;
  localparam int unsigned DEF_NUM_BEATS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } pc_state_t;

  // Bits needed to hold the count of ones in a w-bit word.
  function automatic int unsigned count_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  // Bits needed to hold the total over nb beats of cw bits each.
  function automatic int unsigned sum_width(input int unsigned cw, input int unsigned nb);
    return $clog2(cw * nb + 1);
  endfunction

  // Bits needed to hold a beat count of 0..nb.
  function automatic int unsigned beat_width(input int unsigned nb);
    return $clog2(nb + 1);
  endfunction

endpackage

// File: rtl/popcount_chunk.sv
// Exact combinational popcount of one W-bit word, built as a balanced
// binary adder tree. Interface is shared with approximate variants.
module popcount_chunk
  import popcount_pkg::*;
#(
  parameter  int unsigned W  = DEF_CHUNK_W,
  localparam int unsigned CW = count_width(W)
) (
  input  logic [W-1:0]  input_a,
  output logic [CW-1:0] count
);

  // Heap-ordered tree: leaves at W..2W-1, node i sums nodes 2i and 2i+1,
  // node 1 is the root. Works for any W, not only powers of two.
  logic [CW-1:0] node [1:2*W-1];

  // Fill leaves, then reduce from the deepest internal node upwards.
  always_comb begin
    node = '{default: '0};
    for (int unsigned i = 0; i < W; i++) begin
      node[W + i] = CW'(input_a[i]);
    end
    for (int unsigned i = W - 1; i >= 1; i--) begin
      node[i] = node[2 * i] + node[2 * i + 1];
    end
  end

  assign count = node[1];

endmodule

// File: rtl/popcount_seq_acc.sv
// Sequential popcount accumulator: counts ones over a vector delivered as
// CHUNK_W-bit beats and presents the total on a valid/ready output.
// Optional feature macro: POPCOUNT_THRESH_EN (adds out_fire = sum >= THRESH).
module popcount_seq_acc
  import popcount_pkg::*;
#(
  parameter  int unsigned CHUNK_W   = DEF_CHUNK_W,
  parameter  int unsigned NUM_BEATS = DEF_NUM_BEATS,
`ifdef POPCOUNT_THRESH_EN
  parameter  int unsigned THRESH    = 38,
`endif
  localparam int unsigned SUM_W     = sum_width(CHUNK_W, NUM_BEATS),
  localparam int unsigned BEAT_W    = beat_width(NUM_BEATS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [CHUNK_W-1:0] input_a,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SUM_W-1:0]   out_sum,
  output logic [BEAT_W-1:0]  out_beats
`ifdef POPCOUNT_THRESH_EN
  ,
  output logic               out_fire
`endif
);

  localparam int unsigned CW = count_width(CHUNK_W);

  pc_state_t         state;
  logic [SUM_W-1:0]  acc;
  logic [BEAT_W-1:0] beats;
  logic [CW-1:0]     beat_count;
  logic [SUM_W-1:0]  acc_next;
  logic [BEAT_W-1:0] beats_next;
  logic              accept;
  logic              vec_end;

  popcount_chunk #(
    .W (CHUNK_W)
  ) u_chunk (
    .input_a (input_a),
    .count   (beat_count)
  );

  assign in_ready   = (state != DONE);
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && in_ready;
  assign acc_next   = ((state == IDLE) ? '0 : acc) + SUM_W'(beat_count);
  assign beats_next = beats + BEAT_W'(1);
  assign vec_end    = in_last || (beats_next == BEAT_W'(NUM_BEATS));

  // Result registers are only exposed while the result is held.
  assign out_sum   = out_valid ? acc   : '0;
  assign out_beats = out_valid ? beats : '0;

`ifdef POPCOUNT_THRESH_EN
  logic fire_q;
  assign out_fire = out_valid && fire_q;
`endif

  // Beat acceptance, vector termination and result hand-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      beats <= '0;
`ifdef POPCOUNT_THRESH_EN
      fire_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, ACC: begin
          if (accept) begin
            acc   <= acc_next;
            beats <= beats_next;
            state <= vec_end ? DONE : ACC;
`ifdef POPCOUNT_THRESH_EN
            // Only the value captured on the final beat is ever visible.
            fire_q <= (32'(acc_next) >= THRESH);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
            acc   <= '0;
            beats <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_seq_acc.sv
// Self-checking bench for popcount_seq_acc: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_popcount_seq_acc;

  localparam int CW = 19;
  localparam int NB = 4;
  localparam int SW = $clog2(CW * NB + 1);
  localparam int BW = $clog2(NB + 1);
  localparam int TH = 38;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_last = 1'b0;
  logic [CW-1:0] input_a = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [SW-1:0] out_sum;
  logic [BW-1:0] out_beats;
`ifdef POPCOUNT_THRESH_EN
  logic          out_fire;
`endif

  popcount_seq_acc #(
    .CHUNK_W   (CW),
    .NUM_BEATS (NB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .input_a   (input_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_beats (out_beats)
`ifdef POPCOUNT_THRESH_EN
    ,
    .out_fire  (out_fire)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Behavioural model: beats of the open vector kept as raw words, result
  // computed by counting ones over all of them when the vector closes.
  bit            m_held = 1'b0;
  int            m_sum = 0;
  int            m_beats = 0;
  logic [CW-1:0] cur_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_held = 1'b0;
      cur_q.delete();
    end else if (m_held) begin
      if (out_ready) m_held = 1'b0;
    end else if (in_valid) begin
      cur_q.push_back(input_a);
      if (in_last || cur_q.size() == NB) begin
        m_sum = 0;
        foreach (cur_q[i]) m_sum += $countones(cur_q[i]);
        m_beats = cur_q.size();
        m_held = 1'b1;
        cur_q.delete();
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Offer one beat and wait until it is taken; in_valid drops afterwards.
  task automatic send_beat(input logic [CW-1:0] d, input logic last);
    bit taken = 1'b0;
    in_valid = 1'b1;
    input_a  = d;
    in_last  = last;
    for (int k = 0; k < 50 && !taken; k++) begin
      taken = in_ready;
      tick();
    end
    if (!taken) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout actual=not_taken required=taken at %0t", $time);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  in_ready,  !m_held);
      chk("out_valid", out_valid, m_held);
      chk("out_sum",   out_sum,   m_held ? m_sum : 0);
      chk("out_beats", out_beats, m_held ? m_beats : 0);
`ifdef POPCOUNT_THRESH_EN
      chk("out_fire",  out_fire,  m_held && (m_sum >= TH));
`endif
    end
  end

  initial begin
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum",   out_sum,   0);
    chk("rst_out_beats", out_beats, 0);

    // Four full beats, in_last on the fourth.
    for (int b = 0; b < 4; b++) send_beat(19'h7FFFF, b == 3);
    chk("t1_valid", out_valid, 1);
    chk("t1_sum",   out_sum,   76);
    chk("t1_beats", out_beats, 4);
    chk("t1_ready", in_ready,  0);
`ifdef POPCOUNT_THRESH_EN
    chk("t1_fire",  out_fire,  1);
`endif
    release_result();
    chk("t1_idle",  in_ready,  1);

    // Short vector closed by in_last.
    send_beat(19'h00001, 1'b0);
    send_beat(19'h00003, 1'b1);
    chk("t2_sum",   out_sum,   3);
    chk("t2_beats", out_beats, 2);
    release_result();

    // No in_last: closes at NUM_BEATS, fifth beat stalls while held.
    for (int b = 0; b < 4; b++) send_beat(19'h0000F, 1'b0);
    in_valid = 1'b1;
    input_a  = 19'h0000F;
    in_last  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("t3_stall_ready", in_ready, 0);
      tick();
    end
    chk("t3_sum",   out_sum,   16);
    chk("t3_beats", out_beats, 4);
    out_ready = 1'b1;
    send_beat(19'h0000F, 1'b1);
    chk("t3_next_sum",   out_sum,   4);
    chk("t3_next_beats", out_beats, 1);
    tick();
    out_ready = 1'b0;
    chk("t3_back_idle", in_ready, 1);

    // Reset in the middle of a vector discards the partial sum.
    send_beat(19'h7FFFF, 1'b0);
    send_beat(19'h7FFFF, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_valid", out_valid, 0);
    chk("t4_ready", in_ready,  1);
    send_beat(19'h00005, 1'b1);
    chk("t4_sum",   out_sum,   2);
    chk("t4_beats", out_beats, 1);
    release_result();

    // Threshold boundary: 37 and 38.
    send_beat(19'h7FFFF, 1'b0);
    send_beat(19'h7FFFE, 1'b1);
    chk("t5_sum37", out_sum, 37);
`ifdef POPCOUNT_THRESH_EN
    chk("t5_fire37", out_fire, 0);
`endif
    release_result();
    send_beat(19'h7FFFF, 1'b0);
    send_beat(19'h7FFFF, 1'b1);
    chk("t5_sum38", out_sum, 38);
`ifdef POPCOUNT_THRESH_EN
    chk("t5_fire38", out_fire, 1);
`endif
    release_result();

    // Randomized traffic, including occasional resets.
    for (int k = 0; k < 3000; k++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 1) == 1);
      rst       = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 3))
        0:       input_a = '1;
        1:       input_a = '0;
        default: input_a = CW'($urandom);
      endcase
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
